// File: rtl/uart_rx_byte_stage.sv
// UART 8N1 receive stage with a single-entry holding register.
//   clk        : system clock, rising edge
//   reset_n    : asynchronous active-low reset
//   rx         : asynchronous serial line, idle high
//   rx_data    : received byte, LSB = first data bit on the line
//   rx_valid   : rx_data holds an unconsumed byte
//   rx_ready   : downstream accepts rx_data when rx_valid is high
//   frame_err  : one-cycle pulse, stop bit sampled low
//   overrun    : one-cycle pulse, completed byte dropped (holding register full)
module uart_rx_byte_stage #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned TMR_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned HALF_BIT  = CLKS_PER_BIT / 2;
    localparam logic [TMR_W-1:0] BIT_LAST  = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [TMR_W-1:0] HALF_LAST = TMR_W'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t             state_q, state_d;
    logic               rx_meta_q, rx_s_q;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [7:0]         shift_q, shift_d;
    logic [7:0]         data_q, data_d;
    logic               valid_q, valid_d;
    logic               ferr_q, ferr_d;
    logic               ovr_q, ovr_d;
    logic               deliver;

    // Two-flop synchronizer; idles high so reset looks like an idle line
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    // Next-state, bit timing and holding-register control
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        deliver = 1'b0;

        // Handshake retires the held byte; a same-cycle delivery re-asserts below
        if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    tmr_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tmr_q == HALF_LAST) begin
                    tmr_d = '0;
                    if (!rx_s_q) begin
                        cnt_d   = '0;
                        state_d = S_DATA;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_DATA: begin
                if (tmr_q == BIT_LAST) begin
                    tmr_d   = '0;
                    // Shift right so the first bit ends up in bit 0
                    shift_d = {rx_s_q, shift_q[7:1]};
                    if (cnt_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_STOP: begin
                if (tmr_q == BIT_LAST) begin
                    tmr_d = '0;
                    if (rx_s_q) begin
                        deliver = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_WAIT_HIGH;
                    end
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_WAIT_HIGH: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (deliver) begin
            if (!valid_q || rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_byte_stage.sv
// Directed bench for uart_rx_byte_stage at 8 clocks per bit.
module tb_uart_rx_byte_stage;

    localparam int unsigned CPB = 8;
    // Start drive to first rx_valid: 2 sync + 1 idle detect + 4 half bit + 9 bits * 8
    localparam int unsigned VALID_LAT = 79;

    logic       clk;
    logic       reset_n;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;

    int n_checks = 0;
    int n_errors = 0;

    int cyc = 0;
    int start_cyc = 0;
    int n_vrise = 0;
    int rise_cyc = 0;
    logic [7:0] rise_data = 8'h00;
    int n_ferr = 0;
    int n_ovr = 0;
    int n_both = 0;
    logic valid_prev = 1'b0;

    int b_v, b_f, b_o;

    uart_rx_byte_stage #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Event monitor sampled away from the active edge
    always @(negedge clk) begin
        if (rx_valid && !valid_prev) begin
            n_vrise++;
            rise_cyc  = cyc;
            rise_data = rx_data;
        end
        valid_prev = rx_valid;
        if (frame_err) n_ferr++;
        if (overrun) n_ovr++;
        if (frame_err && overrun) n_both++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; drives one 8N1 frame
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        start_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        rx = 1'b1;
    endtask

    task automatic snap();
        b_v = n_vrise;
        b_f = n_ferr;
        b_o = n_ovr;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n  = 1'b0;
        rx       = 1'b1;
        rx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_data", 32'(rx_data), 32'h00);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        reset_n = 1'b1;
        idle(4);

        // Clean frame with downstream ready
        rx_ready = 1'b1;
        snap();
        send_byte(8'hA5, 1'b1);
        idle(2);
        check("a5_vcount", 32'(n_vrise - b_v), 32'd1);
        check("a5_data", 32'(rise_data), 32'hA5);
        check("a5_latency", 32'(rise_cyc - start_cyc), 32'(VALID_LAT));
        check("a5_valid_drop", 32'(rx_valid), 32'd0);
        check("a5_ferr", 32'(n_ferr - b_f), 32'd0);
        check("a5_ovr", 32'(n_ovr - b_o), 32'd0);
        idle(CPB);

        // Overrun: holding register full, second byte dropped
        rx_ready = 1'b0;
        snap();
        send_byte(8'h3C, 1'b1);
        send_byte(8'hC3, 1'b1);
        idle(2);
        check("ovr_count", 32'(n_ovr - b_o), 32'd1);
        check("ovr_vcount", 32'(n_vrise - b_v), 32'd1);
        check("ovr_valid_held", 32'(rx_valid), 32'd1);
        check("ovr_data_kept", 32'(rx_data), 32'h3C);
        rx_ready = 1'b1;
        idle(1);
        check("ovr_consume", 32'(rx_valid), 32'd0);
        check("ovr_data_after", 32'(rx_data), 32'h3C);
        idle(CPB);

        // Framing error followed by a long break, then a good frame
        snap();
        send_byte(8'h55, 1'b0);
        rx = 1'b0;
        idle(30 * CPB);
        rx = 1'b1;
        idle(2 * CPB);
        check("ferr_count", 32'(n_ferr - b_f), 32'd1);
        check("ferr_no_valid", 32'(n_vrise - b_v), 32'd0);
        send_byte(8'h81, 1'b1);
        idle(2);
        check("ferr_next_vcount", 32'(n_vrise - b_v), 32'd1);
        check("ferr_next_data", 32'(rise_data), 32'h81);
        check("ferr_total", 32'(n_ferr - b_f), 32'd1);
        idle(CPB);

        // Short low glitch must be rejected silently
        snap();
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(3 * CPB);
        check("glitch_valid", 32'(n_vrise - b_v), 32'd0);
        check("glitch_ferr", 32'(n_ferr - b_f), 32'd0);
        check("glitch_ovr", 32'(n_ovr - b_o), 32'd0);

        // Reset during data bit 4 of 0xFF aborts the frame
        snap();
        fork
            send_byte(8'hFF, 1'b1);
            begin
                repeat (44) @(posedge clk);
                #2;
                reset_n = 1'b0;
                #1;
                check("midrst_data", 32'(rx_data), 32'h00);
                check("midrst_valid", 32'(rx_valid), 32'd0);
                repeat (3) @(posedge clk);
                #2;
                reset_n = 1'b1;
            end
        join
        idle(2 * CPB);
        check("midrst_none", 32'(n_vrise - b_v), 32'd0);
        send_byte(8'h12, 1'b1);
        idle(2);
        check("midrst_vcount", 32'(n_vrise - b_v), 32'd1);
        check("midrst_data12", 32'(rise_data), 32'h12);
        check("midrst_ferr", 32'(n_ferr - b_f), 32'd0);
        idle(CPB);

        // Handshake on the same cycle as the next delivery
        rx_ready = 1'b0;
        send_byte(8'h44, 1'b1);
        idle(CPB);
        check("hs_pre_valid", 32'(rx_valid), 32'd1);
        check("hs_pre_data", 32'(rx_data), 32'h44);
        snap();
        fork
            send_byte(8'h99, 1'b1);
            begin
                repeat (VALID_LAT - 1) @(posedge clk);
                #1;
                rx_ready = 1'b1;
                @(posedge clk);
                #1;
                rx_ready = 1'b0;
            end
        join
        idle(2);
        check("hs_valid", 32'(rx_valid), 32'd1);
        check("hs_data", 32'(rx_data), 32'h99);
        check("hs_ovr", 32'(n_ovr - b_o), 32'd0);
        rx_ready = 1'b1;
        idle(1);
        check("hs_drain", 32'(rx_valid), 32'd0);
        rx_ready = 1'b0;

        check("never_both", 32'(n_both), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
